// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor. It produces |a - b| and a sign flag,
//   one decimal digit per clock, least significant digit first.
//   First pass (SUB): add a to the nine's complement of b, with an initial
//   carry of 1. A final carry of 1 means a >= b and the result is ready.
//   Otherwise the result is the ten's complement of the magnitude, so a
//   second pass (COMP) re-complements it.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request pulse, accepted only while idle
//   a, b     : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy     : high while a pass (SUB or COMP) is running
//   done     : one-cycle pulse when diff/negative/invalid are valid
//   diff     : |a - b| in packed BCD, held until the next accepted start
//   negative : 1 when a < b
//   invalid  : 1 when a latched operand contained a digit above 9
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  negative,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            neg_q, neg_d;
  logic            inv_q, inv_d;

  // Operand-digit range check. It is used only on the first SUB cycle,
  // while a_q and b_q still hold the operands exactly as latched.
  logic [DIGITS-1:0] bad_digit;
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_check
      assign bad_digit[gi] = (a_q[4*gi +: 4] > 4'd9) || (b_q[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Single shared digit cell. The operands are shifted right each cycle,
  // so the active digit is always in bits [3:0]. During COMP the minuend
  // is forced to 0 and the subtrahend becomes the partial result digit.
  logic [3:0] op_x, op_y;
  logic [4:0] sum;
  logic [3:0] r_dig;
  logic       c_out;
  logic [W-1:0] r_shift;

  always_comb begin
    op_x  = (state_q == COMP) ? 4'd0 : a_q[3:0];
    op_y  = (state_q == COMP) ? r_q[3:0] : b_q[3:0];
    // Maximum is 9 + 9 + 1 = 19, which fits in 5 bits.
    sum   = {1'b0, op_x} + {1'b0, 4'd9 - op_y} + {4'b0000, carry_q};
    if (sum > 5'd9) begin
      r_dig = sum[3:0] + 4'd6;
      c_out = 1'b1;
    end else begin
      r_dig = sum[3:0];
      c_out = 1'b0;
    end
    // The new digit enters at the top. After DIGITS shifts the digits are
    // back in order, with digit 0 at the bottom.
    r_shift = W'({r_dig, r_q} >> 4);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    inv_d   = inv_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          idx_d   = '0;
          carry_d = 1'b1;
          inv_d   = 1'b0;
          state_d = SUB;
        end
      end

      SUB: begin
        if ((idx_q == '0) && (|bad_digit)) begin
          diff_d  = '0;
          neg_d   = 1'b0;
          inv_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d     = r_shift;
          a_d     = a_q >> 4;
          b_d     = b_q >> 4;
          carry_d = c_out;
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST) begin
            idx_d = '0;
            if (c_out) begin
              diff_d  = r_shift;
              neg_d   = 1'b0;
              state_d = DONE;
            end else begin
              carry_d = 1'b1;
              state_d = COMP;
            end
          end
        end
      end

      COMP: begin
        r_d     = r_shift;
        carry_d = c_out;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          diff_d  = r_shift;
          neg_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
    end
  end

  assign busy     = (state_q == SUB) || (state_q == COMP);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign negative = neg_q;
  assign invalid  = inv_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, negative, invalid;
  logic [W-1:0] diff;

  int tests_run    = 0;
  int tests_failed = 0;

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .negative(negative), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic longint bcd_val(input logic [W-1:0] x);
    longint v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] x);
    bit bad = 0;
    for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  task automatic ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           output logic [W-1:0] e_diff, output logic e_neg,
                           output logic e_inv, output int e_lat);
    longint va, vb;
    if (has_bad(ta) || has_bad(tb_)) begin
      e_diff = '0; e_neg = 0; e_inv = 1; e_lat = 1;
    end else begin
      va = bcd_val(ta);
      vb = bcd_val(tb_);
      e_inv  = 0;
      e_neg  = (va < vb);
      e_diff = to_bcd(e_neg ? vb - va : va - vb);
      e_lat  = e_neg ? 2 * D : D;
    end
  endtask

  // Drives one request and measures edges from the start edge to done.
  // inject >= 0 pulses a second (different) start that many cycles in.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int inject,
                       output int lat, output int busy_n, output logic done_next);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_n = 0;
    for (int k = 1; k <= 64; k++) begin
      if (busy) busy_n++;
      start = (k - 1 == inject);
      if (k - 1 == inject) begin
        a = ~ta; b = tb_ ^ 16'h1111;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    done_next = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (diff !== '0 || negative !== 1'b0 || invalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got diff=%h neg=%b inv=%b busy=%b done=%b, want all zero",
               diff, negative, invalid, busy, done);
    end
    @(negedge clk) rst = 1'b0;
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_directed();
    logic [W-1:0] va [7] = '{16'h1234, 16'h0034, 16'h5555, 16'h0000, 16'h9999, 16'h12A4, 16'h9999};
    logic [W-1:0] vb [7] = '{16'h0034, 16'h1234, 16'h5555, 16'h0001, 16'h0000, 16'h0001, 16'h9999};
    logic [W-1:0] e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn;
    for (int i = 0; i < 7; i++) begin
      ref_model(va[i], vb[i], e_diff, e_neg, e_inv, e_lat);
      do_op(va[i], vb[i], -1, lat, bn, dn);
      tests_run++;
      if (lat !== e_lat || bn !== e_lat) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy=%0d, want %0d", i, lat, bn, e_lat);
      end
      tests_run++;
      if (diff !== e_diff || negative !== e_neg || invalid !== e_inv) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got diff=%h neg=%b inv=%b, want diff=%h neg=%b inv=%b",
                 i, diff, negative, invalid, e_diff, e_neg, e_inv);
      end
      tests_run++;
      if (dn !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_done_pulse[%0d]: done still %b next cycle, want 0", i, dn);
      end
      $display("[TB] directed a=%h b=%h diff=%h neg=%b inv=%b lat=%0d", va[i], vb[i], diff, negative, invalid, lat);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn, dcount;
    ref_model(16'h0420, 16'h0777, e_diff, e_neg, e_inv, e_lat);
    do_op(16'h0420, 16'h0777, -1, lat, bn, dn);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      a = 16'(k * 16'h1111); b = 16'h0321;
      @(posedge clk); #1;
      if (done) dcount++;
    end
    tests_run++;
    if (diff !== e_diff || negative !== e_neg || dcount !== 0) begin
      tests_failed++;
      $display("FAIL hold: got diff=%h neg=%b extra_done=%0d, want diff=%h neg=%b extra_done=0",
               diff, negative, dcount, e_diff, e_neg);
    end
    $display("[TB] hold diff=%h neg=%b", diff, negative);
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb_, e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ta[4*i +: 4] = 4'($urandom_range(0, 9));
        tb_[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) ta[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) tb_[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) tb_ = ta;
      ref_model(ta, tb_, e_diff, e_neg, e_inv, e_lat);
      do_op(ta, tb_, -1, lat, bn, dn);
      tests_run++;
      if (lat !== e_lat || bn !== e_lat || dn !== 1'b0 ||
          diff !== e_diff || negative !== e_neg || invalid !== e_inv) begin
        tests_failed++;
        $display("FAIL random[%0d]: a=%h b=%h got diff=%h neg=%b inv=%b lat=%0d busy=%0d dn=%b, want diff=%h neg=%b inv=%b lat=%0d",
                 n, ta, tb_, diff, negative, invalid, lat, bn, dn, e_diff, e_neg, e_inv, e_lat);
      end
      $display("[TB] random a=%h b=%h diff=%h neg=%b inv=%b lat=%0d", ta, tb_, diff, negative, invalid, lat);
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn, dcount;
    ref_model(16'h4321, 16'h0123, e_diff, e_neg, e_inv, e_lat);
    do_op(16'h4321, 16'h0123, 2, lat, bn, dn);
    tests_run++;
    if (lat !== e_lat || diff !== e_diff || negative !== e_neg || invalid !== e_inv) begin
      tests_failed++;
      $display("FAIL start_ignored: got lat=%0d diff=%h neg=%b inv=%b, want lat=%0d diff=%h neg=%b",
               lat, diff, negative, invalid, e_lat, e_diff, e_neg);
    end
    dcount = 0;
    for (int k = 0; k < 2 * D + 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    tests_run++;
    if (dn !== 1'b0 || dcount !== 0) begin
      tests_failed++;
      $display("FAIL start_ignored_queue: got dn=%b activity=%0d, want 0 and 0", dn, dcount);
    end
    $display("[TB] start_ignored diff=%h lat=%0d", diff, lat);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn, dcount;
    @(negedge clk);
    a = 16'h0034; b = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (diff !== '0 || negative !== 1'b0 || invalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got diff=%h neg=%b inv=%b busy=%b done=%b, want all zero",
               diff, negative, invalid, busy, done);
    end
    @(negedge clk) rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 2 * D + 2; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    tests_run++;
    if (dcount !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", dcount);
    end
    ref_model(16'h0034, 16'h1234, e_diff, e_neg, e_inv, e_lat);
    do_op(16'h0034, 16'h1234, -1, lat, bn, dn);
    tests_run++;
    if (lat !== e_lat || diff !== e_diff || negative !== e_neg || invalid !== e_inv) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: got lat=%0d diff=%h neg=%b inv=%b, want lat=%0d diff=%h neg=%b",
               lat, diff, negative, invalid, e_lat, e_diff, e_neg);
    end
    $display("[TB] reset_mid recover diff=%h neg=%b", diff, negative);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e_diff; logic e_neg, e_inv, dn; int e_lat, lat, bn;
    logic [W-1:0] va [3] = '{16'h0001, 16'h8000, 16'h0999};
    logic [W-1:0] vb [3] = '{16'h9999, 16'h0001, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      ref_model(va[i], vb[i], e_diff, e_neg, e_inv, e_lat);
      do_op(va[i], vb[i], -1, lat, bn, dn);
      tests_run++;
      if (lat !== e_lat || diff !== e_diff || negative !== e_neg || invalid !== e_inv) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got lat=%0d diff=%h neg=%b inv=%b, want lat=%0d diff=%h neg=%b",
                 i, lat, diff, negative, invalid, e_lat, e_diff, e_neg);
      end
      $display("[TB] back_to_back a=%h b=%h diff=%h neg=%b", va[i], vb[i], diff, negative);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
